// File: rtl/jt12_pg_seq_if.sv
// Slot-multiplexed phase generator bus: per-slot increment inputs and tagged phase outputs.
interface jt12_pg_seq_if #(
  parameter int unsigned SLOTS   = 24,
  parameter int unsigned PHASE_W = 20,
  parameter int unsigned SW      = $clog2(SLOTS)
);
  logic [16:0]        phinc_in;
  logic [5:0]         detune_in;
  logic [3:0]         mul;
  logic               pg_rst;
  logic [SW-1:0]      slot_cnt;
  logic               zero;
  logic [PHASE_W-1:0] phase_out;
  logic [9:0]         phase_op;
  logic [SW-1:0]      out_slot;

  modport master (
    output phinc_in, detune_in, mul, pg_rst,
    input  slot_cnt, zero, phase_out, phase_op, out_slot
  );

  modport slave (
    input  phinc_in, detune_in, mul, pg_rst,
    output slot_cnt, zero, phase_out, phase_op, out_slot
  );
endinterface

// File: rtl/jt12_pg_seq.sv
// Time-multiplexed phase generator: detune, MUL scaling and per-slot phase accumulation,
// three enabled cycles from input to tagged phase output.
module jt12_pg_seq #(
  parameter int unsigned SLOTS   = 24,
  parameter int unsigned PHASE_W = 20,
  parameter int unsigned SW      = $clog2(SLOTS)
) (
  input logic           clk,
  input logic           rst_n,
  input logic           clk_en,
  jt12_pg_seq_if.slave  bus
);

  logic [SW-1:0]      slot_q, slot_d;

  // S1: detuned increment plus the controls it travels with
  logic [16:0]        inc1_q, inc1_d;
  logic [3:0]         mul1_q;
  logic [SW-1:0]      slot1_q;
  logic               rst1_q;

  // S2: scaled increment
  logic [PHASE_W-1:0] inc2_q, inc2_d;
  logic [SW-1:0]      slot2_q;
  logic               rst2_q;

  // S3: accumulated phase and per-slot storage
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [SW-1:0]      out_slot_q;
  logic [PHASE_W-1:0] mem_q [SLOTS];

  logic [20:0]        prod;

  always_comb begin
    slot_d = (slot_q == SW'(SLOTS - 1)) ? '0 : slot_q + SW'(1);
    inc1_d = bus.phinc_in + {{11{bus.detune_in[5]}}, bus.detune_in};

    // MUL of 0 means one half
    if (mul1_q == 4'd0) begin
      prod = {4'b0, inc1_q >> 1};
    end else begin
      prod = {4'b0, inc1_q} * {17'b0, mul1_q};
    end
    inc2_d = PHASE_W'(prod);

    phase_d = rst2_q ? '0 : mem_q[slot2_q] + inc2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      inc1_q     <= '0;
      mul1_q     <= '0;
      slot1_q    <= '0;
      rst1_q     <= 1'b0;
      inc2_q     <= '0;
      slot2_q    <= '0;
      rst2_q     <= 1'b0;
      phase_q    <= '0;
      out_slot_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clk_en) begin
      slot_q     <= slot_d;
      inc1_q     <= inc1_d;
      mul1_q     <= bus.mul;
      slot1_q    <= slot_q;
      rst1_q     <= bus.pg_rst;
      inc2_q     <= inc2_d;
      slot2_q    <= slot1_q;
      rst2_q     <= rst1_q;
      phase_q    <= phase_d;
      out_slot_q <= slot2_q;
      // A slot's next read is SLOTS cycles away, so write-back never races its own read
      mem_q[slot2_q] <= phase_d;
    end
  end

  assign bus.slot_cnt  = slot_q;
  assign bus.zero      = (slot_q == '0);
  assign bus.phase_out = phase_q;
  assign bus.phase_op  = phase_q[PHASE_W-1 -: 10];
  assign bus.out_slot  = out_slot_q;

endmodule
